// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and width defaults for the reaction game
package game_pkg;

    localparam int GAME_SCORE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the 1 ms strobe down to a registered 100 ms strobe
module tick_prescaler #(
    parameter int TICKS_PER_TENTH = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic ms1,
    output logic ms100
);

    localparam int CW = (TICKS_PER_TENTH > 1) ? $clog2(TICKS_PER_TENTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_TENTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ms100_q, ms100_d;

    // Count ms1 only while running; hold otherwise; pulse ms100 on wrap.
    always_comb begin
        cnt_d   = cnt_q;
        ms100_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run && ms1) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                ms100_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and strobe registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            ms100_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ms100_q <= ms100_d;
        end
    end

    assign ms100 = ms100_q;

endmodule

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round sequencer: get-ready countdown, run/pause, scoring, high score
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int TICKS_PER_TENTH = 100,
    parameter int ARM_TENTHS      = 30,
    parameter int SCORE_W         = GAME_SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ms1,
    input  logic               start,
    input  logic               pause,
    input  logic               hit,
    input  logic               timer_done,
    output logic               timer_en,
    output logic               ms100,
    output logic [4:0]         arm_left,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score,
    output logic               playing,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [4:0]         ARM_LOAD  = 5'(ARM_TENTHS);

    game_state_e        state_q, state_d;
    logic [4:0]         arm_q, arm_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic               timer_en_q, timer_en_d;
    logic               playing_q, playing_d;
    logic               game_over_q, game_over_d;
    logic [SCORE_W-1:0] score_inc;
    logic               presc_clr;
    logic               presc_run;
    logic               tick_100;

    // The prescaler only advances while the get-ready or round countdown is live.
    assign presc_run = (state_q == ST_ARM) || (state_q == ST_RUN);

    tick_prescaler #(
        .TICKS_PER_TENTH (TICKS_PER_TENTH)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (presc_clr),
        .run   (presc_run),
        .ms1   (ms1),
        .ms100 (tick_100)
    );

    // Next-state, counters and registered output values for the round FSM.
    always_comb begin
        state_d   = state_q;
        arm_d     = arm_q;
        score_d   = score_q;
        hi_d      = hi_q;
        presc_clr = 1'b0;
        score_inc = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ARM;
                    arm_d     = ARM_LOAD;
                    score_d   = '0;
                    presc_clr = 1'b1;
                end
            end
            ST_ARM: begin
                if (tick_100) begin
                    if (arm_q <= 5'd1) begin
                        arm_d   = 5'd0;
                        state_d = ST_RUN;
                    end else begin
                        arm_d = arm_q - 5'd1;
                    end
                end
            end
            ST_RUN: begin
                if (timer_done) begin
                    // A hit landing with the expiry still counts toward the final score.
                    if (hit) begin
                        score_d = score_inc;
                        hi_d    = (score_inc > hi_q) ? score_inc : hi_q;
                    end else begin
                        hi_d    = (score_q > hi_q) ? score_q : hi_q;
                    end
                    state_d = ST_OVER;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (hit) begin
                    score_d = score_inc;
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    state_d   = ST_ARM;
                    arm_d     = ARM_LOAD;
                    score_d   = '0;
                    presc_clr = 1'b1;
                end else if (pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d   = ST_ARM;
                    arm_d     = ARM_LOAD;
                    score_d   = '0;
                    presc_clr = 1'b1;
                end
            end
            default: begin
                // Corrupted state: recover to IDLE but keep the high score.
                state_d   = ST_IDLE;
                arm_d     = 5'd0;
                score_d   = '0;
                presc_clr = 1'b1;
            end
        endcase

        timer_en_d  = (state_d == ST_RUN);
        playing_d   = (state_d == ST_RUN);
        game_over_d = (state_d == ST_OVER);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            arm_q       <= 5'd0;
            score_q     <= '0;
            hi_q        <= '0;
            timer_en_q  <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            score_q     <= score_d;
            hi_q        <= hi_d;
            timer_en_q  <= timer_en_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
        end
    end

    assign timer_en  = timer_en_q;
    assign ms100     = tick_100;
    assign arm_left  = arm_q;
    assign score     = score_q;
    assign hi_score  = hi_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;

endmodule
